enemy_missile: RTL and testbench
================================

# enemy_missile

Owns the single missile of one AI tank. Sits directly downstream of the AI tank controller, which supplies the fire request, launch point and facing. The block latches a launch, advances the missile one step per frame, detects the play-field border and retires on collision through a timed explosion phase. It then enforces a re-fire cooldown, and its position and status outputs drive the colour mapper and the collision logic.

## Interface
- MISSILE_STEP, 4: pixels moved per frame
- MISSILE_SIZE, 4: missile edge length in pixels (square)
- FIELD_X_MAX, 256: exclusive right bound of the play field
- FIELD_Y_MAX, 256: exclusive bottom bound of the play field
- EXPLODE_FRAMES, 8: frames the explosion is shown
- COOLDOWN_FRAMES, 16: frames after retirement before a new launch is accepted

Ports:
- frame_clk  in  1  single clock, one edge per video frame
- Reset  in  1  synchronous, active-low reset (sampled on frame_clk)
- Missile_on  in  1  fire request from the AI tank, level-sensitive
- Xstart, Ystart  in  10 each  launch point (top-left of the missile)
- TankType  in  2  tank facing at launch: 00 up, 01 left, 10 down, 11 right
- Missile_Collision  in  1  current missile box overlaps a wall, tank or missile
- MissileX, MissileY  out  10 each  current missile top-left
- MissileDir  out  2  latched direction (same encoding as TankType)
- Missile_active  out  1  missile in flight (draw it, test collisions)
- Explode_active  out  1  explosion sprite to be drawn at MissileX/MissileY
- Missile_hit  out  1  one-frame pulse on the frame a collision is accepted
- Fire_ready  out  1  a launch would be accepted this frame

## Operation
- States: IDLE, FLIGHT, EXPLODE. Counters: cooldown (5 bits), explode timer (4 bits).
- IDLE:
  - Fire_ready = (cooldown == 0).
  - If Fire_ready and Missile_on:
    - latch MissileX = Xstart, MissileY = Ystart, MissileDir = TankType
    - go to FLIGHT
  - Otherwise, if cooldown != 0, decrement it.
- FLIGHT, evaluated in priority order:
  1. Missile_Collision = 1: go to EXPLODE, hold position, pulse Missile_hit, load explode timer = EXPLODE_FRAMES-1.
  2. The next step would leave the field: go to IDLE with no explosion, load cooldown = COOLDOWN_FRAMES. The step leaves the field when any of these holds:
     - up: MissileY < MISSILE_STEP
     - left: MissileX < MISSILE_STEP
     - down: MissileY + MISSILE_SIZE + MISSILE_STEP > FIELD_Y_MAX
     - right: MissileX + MISSILE_SIZE + MISSILE_STEP > FIELD_X_MAX
  3. Otherwise, move MISSILE_STEP in MissileDir.
- EXPLODE: decrement the timer. When the timer is 0, go to IDLE and load cooldown = COOLDOWN_FRAMES.
- Missile_on, Xstart, Ystart and TankType are ignored outside IDLE. A request made while busy is dropped, not queued.
- TankType changes during flight do not affect MissileDir.
- Arithmetic:
  - All position math is unsigned, 10 bits.
  - Bound comparisons use 11-bit sums so nothing wraps.
  - Subtraction happens only after the bound check passes, so coordinates never underflow.

## Timing
- Reset (Reset = 0 at a frame_clk edge):
  - state IDLE
  - MissileX = MissileY = 0, MissileDir = 00
  - Missile_active = Explode_active = Missile_hit = 0
  - cooldown = 0, explode timer = 0, so Fire_ready = 1 after reset
- Reset has priority over every other event, including mid-flight and mid-explosion. Everything returns to the values above on the same edge.
- Launch latency: a request sampled at edge N gives Missile_active = 1 and MissileX/Y = launch point after edge N. The first move happens at edge N+1.
- Missile_Collision is sampled against the registered position. A collision and an out-of-field condition at the same edge resolve as a collision.
- Missile_hit is high for exactly one frame, coincident with the first Explode_active frame.
- Explode_active is high for exactly EXPLODE_FRAMES frames.
- After retirement, Fire_ready returns COOLDOWN_FRAMES+1 frames later: one frame for the retirement edge, plus COOLDOWN_FRAMES decrements.
- Missile_active and Explode_active are registered, mutually exclusive and never both high.
- Outputs hold their last values in IDLE, except that the active flags are 0.

## Test plan
- Reset: drive Reset low for 2 frames with Missile_on = 1. Expect all outputs zero and no launch. Release: the launch happens on the first high frame.
- Launch up from (100,100): Missile_active rises 1 frame later at (100,100), then Y = 96, 92, …, 4, 0. From Y = 0 (< 4), retire to IDLE with no Explode_active. Fire_ready is 0 for 17 frames.
- Launch right from (240,50): it moves to 244, 248 and 252. At 252, 252+4+4 > 256, so it retires.
- Collision: launch down from (20,20) and raise Missile_Collision on the 3rd flight frame. Expect:
  - position held at (20,28)
  - one Missile_hit pulse
  - Explode_active for 8 frames, then IDLE
- Busy and cooldown: hold Missile_on = 1 continuously. Expect no relaunch during flight, explosion or the 16-frame cooldown. TankType toggling mid-flight leaves MissileDir unchanged.
- Simultaneous events and reset mid-explosion:
  - Collision together with the out-of-field condition at Y = 2 moving up: expect EXPLODE.
  - Reset asserted in the 4th explosion frame: Explode_active = 0 and Fire_ready = 1 on the next frame.

Source files
------------

// File: rtl/enemy_missile.sv
// Single-missile controller for one AI tank: launch latch, per-frame flight,
// border retirement, collision explosion and re-fire cooldown.
module enemy_missile #(
  parameter int MISSILE_STEP    = 4,
  parameter int MISSILE_SIZE    = 4,
  parameter int FIELD_X_MAX     = 256,
  parameter int FIELD_Y_MAX     = 256,
  parameter int EXPLODE_FRAMES  = 8,
  parameter int COOLDOWN_FRAMES = 16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Missile_on,
  input  logic [9:0] Xstart,
  input  logic [9:0] Ystart,
  input  logic [1:0] TankType,
  input  logic       Missile_Collision,
  output logic [9:0] MissileX,
  output logic [9:0] MissileY,
  output logic [1:0] MissileDir,
  output logic       Missile_active,
  output logic       Explode_active,
  output logic       Missile_hit,
  output logic       Fire_ready
);

  typedef enum logic [1:0] {IDLE, FLIGHT, EXPLODE} state_e;

  localparam logic [1:0]  DIR_UP    = 2'b00;
  localparam logic [1:0]  DIR_LEFT  = 2'b01;
  localparam logic [1:0]  DIR_DOWN  = 2'b10;
  localparam logic [1:0]  DIR_RIGHT = 2'b11;

  localparam logic [9:0]  STEP     = 10'(MISSILE_STEP);
  localparam logic [10:0] REACH    = 11'(MISSILE_SIZE + MISSILE_STEP);
  localparam logic [10:0] X_LIMIT  = 11'(FIELD_X_MAX);
  localparam logic [10:0] Y_LIMIT  = 11'(FIELD_Y_MAX);
  localparam logic [4:0]  COOL_LD  = 5'(COOLDOWN_FRAMES);
  localparam logic [3:0]  BOOM_LD  = 4'(EXPLODE_FRAMES - 1);

  state_e      state_q;
  logic [9:0]  x_q, y_q;
  logic [1:0]  dir_q;
  logic [4:0]  cool_q;
  logic [3:0]  boom_q;
  logic        active_q, explode_q, hit_q;

  logic [9:0]  x_d, y_d;
  logic        off_field;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    off_field = 1'b0;
    case (dir_q)
      DIR_UP: begin
        off_field = (y_q < STEP);
        y_d       = y_q - STEP;
      end
      DIR_LEFT: begin
        off_field = (x_q < STEP);
        x_d       = x_q - STEP;
      end
      DIR_DOWN: begin
        off_field = ({1'b0, y_q} + REACH) > Y_LIMIT;
        y_d       = y_q + STEP;
      end
      DIR_RIGHT: begin
        off_field = ({1'b0, x_q} + REACH) > X_LIMIT;
        x_d       = x_q + STEP;
      end
    endcase
  end

  // NOTE: synchronous reset lives inside the clocked block; all state uses <=
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= DIR_UP;
      cool_q    <= '0;
      boom_q    <= '0;
      active_q  <= 1'b0;
      explode_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cool_q == '0 && Missile_on) begin
            state_q  <= FLIGHT;
            x_q      <= Xstart;
            y_q      <= Ystart;
            dir_q    <= TankType;
            active_q <= 1'b1;
          end else if (cool_q != '0) begin
            cool_q <= cool_q - 5'd1;
          end
        end
        FLIGHT: begin
          // Collision outranks the border: a hit at the edge still explodes.
          if (Missile_Collision) begin
            state_q   <= EXPLODE;
            boom_q    <= BOOM_LD;
            active_q  <= 1'b0;
            explode_q <= 1'b1;
            hit_q     <= 1'b1;
          end else if (off_field) begin
            state_q  <= IDLE;
            cool_q   <= COOL_LD;
            active_q <= 1'b0;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
          end
        end
        EXPLODE: begin
          if (boom_q == '0) begin
            state_q   <= IDLE;
            cool_q    <= COOL_LD;
            explode_q <= 1'b0;
          end else begin
            boom_q <= boom_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MissileX       = x_q;
  assign MissileY       = y_q;
  assign MissileDir     = dir_q;
  assign Missile_active = active_q;
  assign Explode_active = explode_q;
  assign Missile_hit    = hit_q;
  assign Fire_ready     = (state_q == IDLE) && (cool_q == '0);

endmodule

// File: tb/tb_enemy_missile.sv
// Bench for enemy_missile: directed vector table, directed corner sequences,
// then random traffic against a frame-level reference model.
module tb_enemy_missile;

  localparam int STEP = 4, SIZE = 4, FX = 256, FY = 256, BOOM = 8, COOL = 16;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0, Missile_on = 1'b0, Missile_Collision = 1'b0;
  logic [9:0] Xstart = '0, Ystart = '0;
  logic [1:0] TankType = '0;
  logic [9:0] MissileX, MissileY;
  logic [1:0] MissileDir;
  logic       Missile_active, Explode_active, Missile_hit, Fire_ready;

  enemy_missile dut (
    .frame_clk(frame_clk), .Reset(Reset), .Missile_on(Missile_on),
    .Xstart(Xstart), .Ystart(Ystart), .TankType(TankType),
    .Missile_Collision(Missile_Collision),
    .MissileX(MissileX), .MissileY(MissileY), .MissileDir(MissileDir),
    .Missile_active(Missile_active), .Explode_active(Explode_active),
    .Missile_hit(Missile_hit), .Fire_ready(Fire_ready)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: the missile is either flying, showing an explosion with
  // some frames left, or cooling down for some frames; positions are plain ints.
  bit m_fly, m_hit;
  int m_x, m_y, m_dir, m_boom, m_cool;

  task automatic model_edge();
    int nx, ny;
    bit gone;
    if (!Reset) begin
      m_fly = 0; m_hit = 0; m_x = 0; m_y = 0; m_dir = 0; m_boom = 0; m_cool = 0;
    end else if (m_fly) begin
      m_hit = 0;
      if (Missile_Collision) begin
        m_fly = 0; m_boom = BOOM; m_hit = 1;
      end else begin
        nx = m_x; ny = m_y;
        case (m_dir)
          0: begin ny = m_y - STEP; gone = (ny < 0); end
          1: begin nx = m_x - STEP; gone = (nx < 0); end
          2: begin ny = m_y + STEP; gone = (ny + SIZE > FY); end
          default: begin nx = m_x + STEP; gone = (nx + SIZE > FX); end
        endcase
        if (gone) begin m_fly = 0; m_cool = COOL; end
        else begin m_x = nx; m_y = ny; end
      end
    end else if (m_boom > 0) begin
      m_hit = 0;
      m_boom--;
      if (m_boom == 0) m_cool = COOL;
    end else begin
      m_hit = 0;
      if (m_cool == 0 && Missile_on) begin
        m_fly = 1; m_x = int'(Xstart); m_y = int'(Ystart); m_dir = int'(TankType);
      end else if (m_cool > 0) m_cool--;
    end
  endtask

  function automatic logic [25:0] model_out();
    return {m_fly, (m_boom > 0), m_hit, (!m_fly && m_boom == 0 && m_cool == 0),
            2'(m_dir), 10'(m_x), 10'(m_y)};
  endfunction

  task automatic check_model(input string name);
    check(name, {6'd0, Missile_active, Explode_active, Missile_hit, Fire_ready,
                 MissileDir, MissileX, MissileY}, {6'd0, model_out()});
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cycle(input int rst, input int on, input int xs, input int ys,
                       input int tt, input int coll);
    Reset = 1'(rst); Missile_on = 1'(on); Xstart = 10'(xs); Ystart = 10'(ys);
    TankType = 2'(tt); Missile_Collision = 1'(coll);
    @(posedge frame_clk);
    model_edge();
    @(negedge frame_clk);
  endtask

  task automatic step_check(input string name, input int on, input int tt, input int coll);
    cycle(1, on, 0, 0, tt, coll);
    check_model(name);
  endtask

  typedef struct {
    int rst, on, xs, ys, tt, coll;
    int act, expl, hit, rdy, x, y, dir;
  } vec_t;

  vec_t tbl[9];
  int act_n, boom_n, hit_n, cool_n, miny, launches;

  initial begin
    // Reset with a pending request, then a rightward launch retiring at x=252.
    tbl[0] = '{0, 1, 240, 50, 3, 0,   0, 0, 0, 1,   0,  0, 0};
    tbl[1] = '{0, 1, 240, 50, 3, 0,   0, 0, 0, 1,   0,  0, 0};
    tbl[2] = '{1, 1, 240, 50, 3, 0,   1, 0, 0, 0, 240, 50, 3};
    tbl[3] = '{1, 1,   0,  0, 0, 0,   1, 0, 0, 0, 244, 50, 3};
    tbl[4] = '{1, 1,   7,  9, 1, 0,   1, 0, 0, 0, 248, 50, 3};
    tbl[5] = '{1, 1,   0,  0, 2, 0,   1, 0, 0, 0, 252, 50, 3};
    tbl[6] = '{1, 1,   0,  0, 0, 0,   0, 0, 0, 0, 252, 50, 3};
    tbl[7] = '{1, 1,   5,  5, 0, 0,   0, 0, 0, 0, 252, 50, 3};
    tbl[8] = '{1, 0,   5,  5, 0, 0,   0, 0, 0, 0, 252, 50, 3};

    @(negedge frame_clk);
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].rst, tbl[i].on, tbl[i].xs, tbl[i].ys, tbl[i].tt, tbl[i].coll);
      check($sformatf("vec%0d active", i),  32'(Missile_active), 32'(tbl[i].act));
      check($sformatf("vec%0d explode", i), 32'(Explode_active), 32'(tbl[i].expl));
      check($sformatf("vec%0d hit", i),     32'(Missile_hit),    32'(tbl[i].hit));
      check($sformatf("vec%0d ready", i),   32'(Fire_ready),     32'(tbl[i].rdy));
      check($sformatf("vec%0d x", i),       32'(MissileX),       32'(tbl[i].x));
      check($sformatf("vec%0d y", i),       32'(MissileY),       32'(tbl[i].y));
      check($sformatf("vec%0d dir", i),     32'(MissileDir),     32'(tbl[i].dir));
    end

    // Up from (100,100): 26 flight frames down to Y=0, no explosion, 16 idle cooldown frames.
    for (int i = 0; i < 20; i++) step_check("drain", 0, 0, 0);
    check("ready before up launch", 32'(Fire_ready), 32'd1);
    cycle(1, 1, 100, 100, 0, 0);
    check_model("up launch");
    act_n = 1; boom_n = 0; cool_n = 0; miny = 1000;
    for (int i = 0; i < 50; i++) begin
      step_check("up flight", 0, 0, 0);
      if (Missile_active) begin act_n++; if (MissileY < 10'(miny)) miny = int'(MissileY); end
      if (Explode_active) boom_n++;
      if (!Missile_active && !Fire_ready) cool_n++;
    end
    check("up flight frames", 32'(act_n), 32'd26);
    check("up min y", 32'(miny), 32'd0);
    check("up no explosion", 32'(boom_n), 32'd0);
    check("up cooldown frames", 32'(cool_n), 32'd16);

    // Down from (20,20), collision on the 3rd flight frame, request held throughout.
    cycle(1, 1, 20, 20, 2, 0);
    check_model("down launch");
    step_check("down f2", 1, 0, 0);
    step_check("down f3", 1, 1, 0);
    check("down y before hit", 32'(MissileY), 32'd28);
    step_check("collide", 1, 3, 1);
    check("collide x", 32'(MissileX), 32'd20);
    check("collide y", 32'(MissileY), 32'd28);
    check("collide hit", 32'(Missile_hit), 32'd1);
    boom_n = 1; hit_n = 1; launches = 0;
    for (int i = 0; i < 30; i++) begin
      step_check("boom/cool", 1, i % 4, 0);
      if (Explode_active) boom_n++;
      if (Missile_hit) hit_n++;
      if (Missile_active && launches == 0) begin
        launches = 1;
        check("relaunch frame index", 32'(i), 32'd24);
      end
    end
    check("explode frames", 32'(boom_n), 32'd8);
    check("hit pulses", 32'(hit_n), 32'd1);

    // Mid-flight facing changes must not steer the missile.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 100, 60, 3, 0);
    for (int i = 0; i < 5; i++) begin
      step_check("steer", 1, i % 3, 0);
      check("dir latched", 32'(MissileDir), 32'd3);
    end

    // Collision coincident with border exit at Y=2, then reset in the 4th explosion frame.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 20, 10, 0, 0);
    step_check("edge f2", 0, 0, 0);
    step_check("edge f3", 0, 0, 0);
    check("edge y", 32'(MissileY), 32'd2);
    step_check("edge collide", 0, 0, 1);
    check("edge explode", 32'(Explode_active), 32'd1);
    for (int i = 0; i < 3; i++) step_check("boom hold", 0, 0, 0);
    check("4th boom frame", 32'(Explode_active), 32'd1);
    cycle(0, 1, 0, 0, 0, 0);
    check_model("reset in boom");
    check("reset boom off", 32'(Explode_active), 32'd0);
    check("reset ready", 32'(Fire_ready), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) != 0) ? 1 : 0, int'($urandom_range(1)),
            int'($urandom_range(300)), int'($urandom_range(300)),
            int'($urandom_range(3)), ($urandom_range(15) == 0) ? 1 : 0);
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
